circuit5_ctrl: RTL and testbench

CIRCUIT5_CTRL -- requirements
Module: circuit5_ctrl

---
 rtl/circuit5_ctrl.sv | 101 ++++++++++
 tb/tb_circuit5_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/circuit5_ctrl.sv
// Single-transaction controller for a fixed-latency datapath: latches operands,
// waits LATENCY cycles, captures the results and holds them until the consumer accepts.
module circuit5_ctrl #(
  parameter int DW      = 64,
  parameter int RW      = 32,
  parameter int LATENCY = 2
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [DW-1:0] in_c,
  output logic [DW-1:0] dp_a,
  output logic [DW-1:0] dp_b,
  output logic [DW-1:0] dp_c,
  input  logic [RW-1:0] dp_z,
  input  logic [RW-1:0] dp_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_z,
  output logic [RW-1:0] out_x,
  output logic          busy,
  output logic [15:0]   done_cnt
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       accept;
  logic       capture;
  logic       handshake;

  // Outputs decode the registered state only, so no in_* to out_* path exists.
  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    case (state)
      S_IDLE: begin
        accept = in_valid;
        if (in_valid) state_next = S_WAIT;
      end
      S_WAIT: begin
        capture = (cnt == LAT);
        if (cnt == LAT) state_next = S_DONE;
      end
      S_DONE: begin
        handshake = out_ready;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dp_a     <= '0;
      dp_b     <= '0;
      dp_c     <= '0;
      out_z    <= '0;
      out_x    <= '0;
      done_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        dp_a <= in_a;
        dp_b <= in_b;
        dp_c <= in_c;
        cnt  <= '0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 4'd1;
      end
      if (capture) begin
        out_z <= dp_z;
        out_x <= dp_x;
      end
      // Natural 16-bit wrap is intended; no overflow flag.
      if (handshake) done_cnt <= done_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_circuit5_ctrl.sv
// Directed bench for circuit5_ctrl: reset, latency, stall, hold, back-to-back,
// mid-flight reset and done_cnt wrap, with a registered datapath stub.
module tb_circuit5_ctrl;

  localparam int DW  = 64;
  localparam int RW  = 32;
  localparam int LAT = 2;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a, in_b, in_c;
  logic [DW-1:0] dp_a, dp_b, dp_c;
  logic [RW-1:0] dp_z, dp_x;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_z, out_x;
  logic          busy;
  logic [15:0]   done_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  circuit5_ctrl #(.DW(DW), .RW(RW), .LATENCY(LAT)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
    .dp_z(dp_z), .dp_x(dp_x),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_x(out_x),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 Clk = ~Clk;

  // Datapath model: a=5,b=3,c=1 gives z=A5, x=5A.
  function automatic logic [RW-1:0] f_z(logic [DW-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h0000_00A0;
  endfunction
  function automatic logic [RW-1:0] f_x(logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] c);
    logic [DW-1:0] t;
    t = a ^ b ^ c;
    return t[31:0] ^ 32'h0000_005D;
  endfunction

  logic [RW-1:0] pz [LAT];
  logic [RW-1:0] px [LAT];
  always @(posedge Clk) begin
    pz[0] <= f_z(dp_a);
    px[0] <= f_x(dp_a, dp_b, dp_c);
    for (int i = 1; i < LAT; i++) begin
      pz[i] <= pz[i-1];
      px[i] <= px[i-1];
    end
  end
  assign dp_z = pz[LAT-1];
  assign dp_x = px[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  logic [DW-1:0] va [3];
  logic [DW-1:0] vb [3];
  logic [DW-1:0] vc [3];
  int            acc_cyc [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] ha, hb, hc;
    logic          acc, hs;
    int            k, nres;

    Rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    step(); step();
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_z", out_z, 0);
    check("rst_dp_a", dp_a, 0);
    check("rst_done_cnt", done_cnt, 0);
    Rst = 1'b1;
    step();

    // Basic transaction followed by a 10-cycle stall in DONE
    in_valid = 1'b1; in_a = 64'd5; in_b = 64'd3; in_c = 64'd1;
    step();
    in_valid = 1'b0;
    check("acc_dp_a", dp_a, 5);
    check("acc_dp_b", dp_b, 3);
    check("acc_dp_c", dp_c, 1);
    check("acc_in_ready", in_ready, 0);
    check("acc_busy", busy, 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("lat_out_valid_%0d", i), out_valid, (i == 3) ? 1 : 0);
    end
    check("basic_out_z", out_z, 32'h0000_00A5);
    check("basic_out_x", out_x, 32'h0000_005A);
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_out_valid", out_valid, 1);
      check("stall_out_z", out_z, 32'h0000_00A5);
      check("stall_in_ready", in_ready, 0);
      check("stall_done_cnt", done_cnt, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hs_out_valid", out_valid, 0);
    check("hs_done_cnt", done_cnt, 1);
    check("hs_in_ready", in_ready, 1);
    check("hs_retain_z", out_z, 32'h0000_00A5);
    check("hs_retain_x", out_x, 32'h0000_005A);

    // Operand hold while inputs toggle; stray in_valid/out_ready in WAIT ignored
    ha = 64'h1111_2222_3333_4444; hb = 64'h5555_6666_7777_8888; hc = 64'h9999_AAAA_BBBB_CCCC;
    in_valid = 1'b1; in_a = ha; in_b = hb; in_c = hc;
    step();
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_c = {$urandom, $urandom};
      step();
      check("hold_dp_a", dp_a, ha);
      check("hold_dp_b", dp_b, hb);
      check("hold_dp_c", dp_c, hc);
      check($sformatf("hold_out_valid_%0d", i), out_valid, (i == 3) ? 1 : 0);
    end
    check("hold_out_z", out_z, f_z(ha));
    check("hold_out_x", out_x, f_x(ha, hb, hc));
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("hold_done_cnt", done_cnt, 2);
    check("hold_out_valid_end", out_valid, 0);

    // Reset wins over a simultaneous accept
    in_valid = 1'b1; in_a = 64'h77; in_b = 64'h66; in_c = 64'h55; Rst = 1'b0;
    step();
    check("prio_dp_a", dp_a, 0);
    check("prio_in_ready", in_ready, 1);
    check("prio_done_cnt", done_cnt, 0);
    Rst = 1'b1;

    // Mid-flight reset one cycle after the accept
    step();
    check("mid_acc_dp_a", dp_a, 64'h77);
    in_valid = 1'b0; Rst = 1'b0;
    step();
    Rst = 1'b1;
    check("mid_in_ready", in_ready, 1);
    check("mid_busy", busy, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_dp_a", dp_a, 0);
    check("mid_done_cnt", done_cnt, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("mid_no_result", out_valid, 0);
    end

    // Back-to-back: three requests with in_valid held and out_ready=1
    va[0] = 64'h10; vb[0] = 64'h20; vc[0] = 64'h30;
    va[1] = 64'hDEAD_BEEF_0000_0001; vb[1] = 64'h0F0F; vc[1] = 64'hF0F0;
    va[2] = 64'h0000_0001_8000_0000; vb[2] = 64'h1; vc[2] = 64'h2;
    for (int i = 0; i < 3; i++) acc_cyc[i] = 0;
    k = 0; nres = 0;
    in_valid = 1'b1; in_a = va[0]; in_b = vb[0]; in_c = vc[0]; out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        check($sformatf("b2b_z_%0d", nres), out_z, f_z(va[nres]));
        check($sformatf("b2b_x_%0d", nres), out_x, f_x(va[nres], vb[nres], vc[nres]));
        nres++;
      end
      step();
      if (acc) begin
        acc_cyc[k] = cyc;
        k++;
        if (k < 3) begin
          in_a = va[k]; in_b = vb[k]; in_c = vc[k];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    check("b2b_results", nres, 3);
    check("b2b_gap_01", acc_cyc[1] - acc_cyc[0], LAT + 3);
    check("b2b_gap_12", acc_cyc[2] - acc_cyc[1], LAT + 3);
    check("b2b_done_cnt", done_cnt, 3);

    // done_cnt wrap from FFFF
    force dut.done_cnt = 16'hFFFF;
    #1;
    release dut.done_cnt;
    check("wrap_preload", done_cnt, 16'hFFFF);
    in_valid = 1'b1; in_a = 64'h42; in_b = 64'h1; in_c = 64'h2;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    check("wrap_out_valid", out_valid, 1);
    check("wrap_out_z", out_z, f_z(64'h42));
    step();
    out_ready = 1'b0;
    check("wrap_done_cnt", done_cnt, 16'h0000);
    check("wrap_idle", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
